// File: rtl/pipe_stage_reg.sv
// Two-entry registered pipeline stage (main + skid) with flush.
// Every output is decoded from state registers only, so no input reaches an output combinationally.
module pipe_stage_reg #(
  parameter int              WIDTH  = 96,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'('h13)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q, main_nxt, skid_nxt;
  logic             in_xfer, out_xfer;

  // Reset outranks flush, and both outrank any transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state  <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    in_xfer   = i_valid && o_ready;
    out_xfer  = o_valid && i_ready;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = BUSY;
          main_nxt  = i_data;
        end
      end
      BUSY: begin
        case ({in_xfer, out_xfer})
          2'b11: main_nxt = i_data;
          2'b10: begin
            state_nxt = FULL;
            skid_nxt  = i_data;
          end
          2'b01: begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt = BUSY;
          main_nxt  = skid_q;
          skid_nxt  = BUBBLE;
        end
      end
      default: begin
        state_nxt = EMPTY;
        main_nxt  = BUBBLE;
        skid_nxt  = BUBBLE;
      end
    endcase
  end

  always_comb begin
    o_data  = main_q;
    o_valid = 1'b0;
    o_ready = 1'b1;
    o_count = 2'd0;
    case (state)
      BUSY: begin
        o_valid = 1'b1;
        o_count = 2'd1;
      end
      FULL: begin
        o_valid = 1'b1;
        o_ready = 1'b0;
        o_count = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 96, meaning payload width in bits (e.g. instr+pc+pc_four).
REQ-002 The module SHALL have parameter BUBBLE, default 'h13 zero-extended to WIDTH, meaning the payload presented when the stage holds no entry (NOP).
REQ-003 The module SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port i_flush  input  1  synchronous discard of all held entries.
REQ-006 The module SHALL have port i_valid  input  1  upstream payload valid.
REQ-007 The module SHALL have port i_data  input  WIDTH  upstream payload.
REQ-008 The module SHALL have port o_ready  output  1  stage can accept a payload this cycle.
REQ-009 The module SHALL have port o_valid  output  1  downstream payload valid.
REQ-010 The module SHALL have port o_data  output  WIDTH  downstream payload.
REQ-011 The module SHALL have port i_ready  input  1  downstream accepts payload this cycle.
REQ-012 The module SHALL have port o_count  output  2  occupancy, 0..2.

Function
REQ-013 Storage SHALL be one main register and one skid register; state EMPTY (0 held), BUSY (main held), FULL (main+skid held).
REQ-014 Input transfer SHALL occur when i_valid && o_ready; output transfer SHALL occur when o_valid && i_ready.
REQ-015 o_valid, o_data, o_ready and o_count SHALL be driven directly from registers, with no combinational path from any input.
REQ-016 o_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL; o_valid SHALL be 1 in BUSY and FULL.
REQ-017 o_data SHALL equal the main register; the main register SHALL hold BUBBLE whenever state is EMPTY.
REQ-018 EMPTY with input transfer SHALL go to BUSY with main <= i_data; without one it SHALL remain EMPTY.
REQ-019 BUSY with input and output transfer SHALL remain BUSY with main <= i_data; input only SHALL go to FULL with skid <= i_data; output only SHALL go to EMPTY with main <= BUBBLE; neither SHALL hold.
REQ-020 FULL with output transfer SHALL go to BUSY with main <= skid and skid <= BUBBLE; otherwise it SHALL hold.
REQ-021 Latency SHALL be 1 cycle from input transfer to o_valid when the stage was EMPTY or drained in the same cycle.
REQ-022 Sustained throughput SHALL be 1 payload/cycle while i_ready=1.
REQ-023 While o_valid=1 and i_ready=0, o_data SHALL remain stable and no payload SHALL be dropped, duplicated or reordered.
REQ-024 i_flush=1 SHALL override all transfers: next state EMPTY, main <= BUBBLE, skid <= BUBBLE.
REQ-025 Any payload offered in a flush cycle SHALL be discarded even if o_ready=1.
REQ-026 o_count SHALL be 0/1/2 for EMPTY/BUSY/FULL respectively.

Reset
REQ-027 i_rst=1 SHALL take priority over i_flush and all transfers, forcing EMPTY, main=skid=BUBBLE.
REQ-028 The cycle after i_rst=1 sampled, outputs SHALL be o_valid=0, o_ready=1, o_count=0, o_data=BUBBLE.
REQ-029 Reset asserted mid-operation (BUSY or FULL) SHALL discard held payloads with the same result.

Verification (WIDTH=32, BUBBLE=0x13)
REQ-030 A bench SHALL apply reset, then idle -> o_data=0x13, o_valid=0, o_ready=1, o_count=0.
REQ-031 A bench SHALL stream 0xA0..0xA7 with i_valid=1, i_ready=1 -> o_data 0xA0..0xA7 each one cycle later, o_count=1 throughout, no gaps.
REQ-032 A bench SHALL send 0xB0, 0xB1 with i_ready=0 -> o_count=2, o_ready=0, o_data=0xB0 held; then i_ready=1 -> 0xB0, then 0xB1, then o_valid=0, o_data=0x13.
REQ-033 A bench SHALL raise i_flush in FULL while offering 0xC5 -> next cycle o_count=0, o_data=0x13, and 0xC5 never appears.
REQ-034 A bench SHALL assert i_rst and i_flush together in BUSY with i_valid=1 -> same result as reset alone.
REQ-035 A bench SHALL run random i_valid/i_ready/i_flush for 10k cycles -> scoreboard order preserved, no loss except flushed entries, o_data stable under backpressure.
